// File: rtl/cnn_layer_sequencer.sv
// Layer sequencer for the digit-recognition datapath: walks img_wr, conv1, pool1, conv2, pool2, fc.
// Define SEQ_CYCLE_COUNT_EN to add the 32-bit busy-cycle counter output cycle_count.
module cnn_layer_sequencer #(
    parameter int unsigned IMG_PASSES = 1,
    parameter int unsigned C1_PASSES  = 1,
    parameter int unsigned P1_PASSES  = 1,
    parameter int unsigned C2_PASSES  = 6,
    parameter int unsigned P2_PASSES  = 6,
    parameter int unsigned FC_PASSES  = 1,
    parameter int unsigned DRAIN      = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    input  logic       pix_valid,
    output logic       pix_ready,
    input  logic [5:0] stage_done,
    output logic [5:0] stage_clr,
    output logic [5:0] stage_en,
    output logic [2:0] stage_id,
    output logic [3:0] pass_idx,
    output logic       busy,
    output logic       seq_done
`ifdef SEQ_CYCLE_COUNT_EN
    ,
    output logic [31:0] cycle_count
`endif
);

    typedef enum logic [2:0] {StIdle, StClr, StRun, StDrain, StDone, StAbort} state_e;

    state_e     state_q, state_d;
    logic [2:0] stage_q, stage_d;
    logic [3:0] pass_q, pass_d;
    logic [3:0] drain_q, drain_d;
    logic       pass_end;

    function automatic logic [3:0] last_pass(input logic [2:0] s);
        case (s)
            3'd0:    return 4'(IMG_PASSES - 1);
            3'd1:    return 4'(C1_PASSES - 1);
            3'd2:    return 4'(P1_PASSES - 1);
            3'd3:    return 4'(C2_PASSES - 1);
            3'd4:    return 4'(P2_PASSES - 1);
            default: return 4'(FC_PASSES - 1);
        endcase
    endfunction

    always_comb begin
        state_d   = state_q;
        stage_d   = stage_q;
        pass_d    = pass_q;
        drain_d   = drain_q;
        stage_clr = '0;
        stage_en  = '0;
        pix_ready = 1'b0;
        seq_done  = 1'b0;
        pass_end  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start && !abort) begin
                    state_d = StClr;
                    stage_d = 3'd0;
                    pass_d  = 4'd0;
                end
            end
            StClr: begin
                stage_clr[stage_q] = 1'b1;
                drain_d            = 4'd0;
                state_d            = StRun;
            end
            StRun: begin
                if (stage_done[stage_q]) begin
                    drain_d = 4'd0;
                    if (DRAIN == 0) pass_end = 1'b1;
                    else            state_d  = StDrain;
                end else if (stage_q == 3'd0) begin
                    // Image writes advance only on an accepted pixel.
                    stage_en[0] = pix_valid;
                    pix_ready   = pix_valid;
                end else begin
                    stage_en[stage_q] = 1'b1;
                end
            end
            StDrain: begin
                if (drain_q == 4'(DRAIN - 1)) pass_end = 1'b1;
                else                          drain_d  = drain_q + 4'd1;
            end
            StDone: begin
                seq_done = 1'b1;
                state_d  = StIdle;
            end
            StAbort: begin
                stage_clr = '1;
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (pass_end) begin
            if (pass_q != last_pass(stage_q)) begin
                pass_d  = pass_q + 4'd1;
                state_d = StClr;
            end else if (stage_q != 3'd5) begin
                stage_d = stage_q + 3'd1;
                pass_d  = 4'd0;
                state_d = StClr;
            end else begin
                state_d = StDone;
            end
        end

        // Abort wins over any pass/stage advance; stage and pass stay as they were.
        if (abort && state_q != StIdle && state_q != StAbort) begin
            state_d = StAbort;
            stage_d = stage_q;
            pass_d  = pass_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            stage_q <= 3'd0;
            pass_q  <= 4'd0;
            drain_q <= 4'd0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            pass_q  <= pass_d;
            drain_q <= drain_d;
        end
    end

    assign busy     = (state_q == StClr) || (state_q == StRun) || (state_q == StDrain) ||
                      (state_q == StDone);
    assign stage_id = (state_q == StIdle || state_q == StDone) ? 3'd7 : stage_q;
    assign pass_idx = pass_q;

`ifdef SEQ_CYCLE_COUNT_EN
    logic [31:0] cycle_count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_count_q <= 32'd0;
        end else if (state_q == StIdle && start && !abort) begin
            cycle_count_q <= 32'd0;
        end else if (busy) begin
            cycle_count_q <= cycle_count_q + 32'd1;
        end
    end

    assign cycle_count = cycle_count_q;
`endif

endmodule
